// File: rtl/mem_arbiter.sv
// Two-master (I-cache / D-cache) round-robin arbiter onto a single line-wide RAM port.
// Optional busy watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int BUS_WIDTH_BYTES = 256,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic [31:0]                  ic_address,
    input  logic                         ic_read,
    output logic [BUS_WIDTH_BYTES*8-1:0] ic_rdata,
    output logic                         ic_ready,
    output logic                         ic_done,
    output logic                         ic_err,

    input  logic [31:0]                  dc_address,
    input  logic                         dc_read,
    input  logic                         dc_write,
    input  logic [BUS_WIDTH_BYTES*8-1:0] dc_wdata,
    output logic [BUS_WIDTH_BYTES*8-1:0] dc_rdata,
    output logic                         dc_ready,
    output logic                         dc_done,
    output logic                         dc_err,

    output logic [31:0]                  ram_address,
    output logic                         ram_read,
    output logic                         ram_write,
    output logic [BUS_WIDTH_BYTES*8-1:0] ram_wdata,
    input  logic [BUS_WIDTH_BYTES*8-1:0] ram_rdata,
    input  logic                         ram_ready,
    input  logic                         ram_done
);

    localparam int          W           = BUS_WIDTH_BYTES * 8;
    localparam int          OFFSET_BITS = $clog2(BUS_WIDTH_BYTES);
    localparam logic [31:0] LINE_MASK   = ~((32'd1 << OFFSET_BITS) - 32'd1);
    localparam logic        GRANT_IC    = 1'b0;
    localparam logic        GRANT_DC    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_grant;
    logic           r_last_grant;
    logic           r_is_write;
    logic           r_ready;
    logic [31:0]    r_ram_address;
    logic [W-1:0]   r_ram_wdata;
    logic           r_ram_read;
    logic           r_ram_write;
    logic           r_ic_done;
    logic           r_dc_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]    r_timer;
    logic           r_ic_err;
    logic           r_dc_err;
`endif

    logic           w_ic_req;
    logic           w_dc_req;
    logic           w_pick_dc;
    logic           w_start;
    logic           w_start_write;
    logic [31:0]    w_start_address;
    logic           w_complete;

    assign w_ic_req        = ic_read;
    assign w_dc_req        = dc_read | dc_write;
    // On a tie the master that was not granted last wins.
    assign w_pick_dc       = w_dc_req && (!w_ic_req || (r_last_grant == GRANT_IC));
    assign w_start         = ram_ready && (w_ic_req || w_dc_req);
    assign w_start_write   = w_pick_dc && dc_write;
    assign w_start_address = (w_pick_dc ? dc_address : ic_address) & LINE_MASK;
    assign w_complete      = (r_state == ST_BUSY) && ram_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= GRANT_IC;
            r_last_grant  <= GRANT_IC;
            r_is_write    <= 1'b0;
            r_ready       <= 1'b1;
            r_ram_address <= '0;
            r_ram_wdata   <= '0;
            r_ram_read    <= 1'b0;
            r_ram_write   <= 1'b0;
            r_ic_done     <= 1'b0;
            r_dc_done     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_timer       <= '0;
            r_ic_err      <= 1'b0;
            r_dc_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_grant       <= w_pick_dc ? GRANT_DC : GRANT_IC;
                        r_last_grant  <= w_pick_dc ? GRANT_DC : GRANT_IC;
                        r_is_write    <= w_start_write;
                        r_ram_address <= w_start_address;
                        r_ram_wdata   <= w_pick_dc ? dc_wdata : r_ram_wdata;
                        r_ram_read    <= !w_start_write;
                        r_ram_write   <= w_start_write;
                        r_ready       <= 1'b0;
                        r_state       <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_timer       <= '0;
`endif
                    end
                end

                ST_BUSY: begin
                    if (ram_done) begin
                        r_ram_read  <= 1'b0;
                        r_ram_write <= 1'b0;
                        r_ic_done   <= (r_grant == GRANT_IC);
                        r_dc_done   <= (r_grant == GRANT_DC);
                        r_state     <= ST_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Watchdog expiry completes the transaction with an error flag.
                    else if (r_timer == TIMER_LAST) begin
                        r_ram_read  <= 1'b0;
                        r_ram_write <= 1'b0;
                        r_ic_done   <= (r_grant == GRANT_IC);
                        r_dc_done   <= (r_grant == GRANT_DC);
                        r_ic_err    <= (r_grant == GRANT_IC);
                        r_dc_err    <= (r_grant == GRANT_DC);
                        r_state     <= ST_RESP;
                    end else begin
                        r_timer     <= r_timer + 32'd1;
                    end
`endif
                end

                ST_RESP: begin
                    r_ic_done <= 1'b0;
                    r_dc_done <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    r_ic_err  <= 1'b0;
                    r_dc_err  <= 1'b0;
`endif
                    r_ready   <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Per-master read-data holding registers; updated only by that master's read completion.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic MASTER_ID = 1'(gi);
            logic [W-1:0] r_rdata;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rdata <= '0;
                end else if (w_complete && !r_is_write && (r_grant == MASTER_ID)) begin
                    r_rdata <= ram_rdata;
                end
            end
        end
    endgenerate

    assign ic_rdata    = g_master[0].r_rdata;
    assign dc_rdata    = g_master[1].r_rdata;
    assign ic_ready    = r_ready;
    assign dc_ready    = r_ready;
    assign ic_done     = r_ic_done;
    assign dc_done     = r_dc_done;
    assign ram_address = r_ram_address;
    assign ram_read    = r_ram_read;
    assign ram_write   = r_ram_write;
    assign ram_wdata   = r_ram_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    assign ic_err = r_ic_err;
    assign dc_err = r_dc_err;
`else
    assign ic_err = 1'b0;
    assign dc_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: arbitration, latency, reset abort, idle ram_done,
// and (with MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) the watchdog path.
module tb_mem_arbiter;

    localparam int BWB = 256;
    localparam int W   = BWB * 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    localparam logic [W-1:0] P1 = {64{32'hA5A5_0001}};
    localparam logic [W-1:0] P2 = {64{32'h5A5A_0002}};
    localparam logic [W-1:0] P3 = {64{32'h1234_0003}};
    localparam logic [W-1:0] P4 = {64{32'hCAFE_0004}};
    localparam logic [W-1:0] P5 = {64{32'hBEEF_0005}};
    localparam logic [W-1:0] P6 = {64{32'h0F0F_0006}};
    localparam logic [W-1:0] P7 = {64{32'hF00D_0007}};
    localparam logic [W-1:0] PJ = {64{32'hDEAD_DEAD}};

    // Control snapshot: {ram_read, ram_write, ic_done, ic_err, dc_done, dc_err, ic_ready, dc_ready}
    localparam logic [7:0] C_IDLE  = 8'b0000_0011;
    localparam logic [7:0] C_RD    = 8'b1000_0000;
    localparam logic [7:0] C_WR    = 8'b0100_0000;
    localparam logic [7:0] C_ICDN  = 8'b0010_0000;
    localparam logic [7:0] C_DCDN  = 8'b0000_1000;
    localparam logic [7:0] C_DCERR = 8'b0000_1100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   ic_address;
    logic          ic_read;
    logic [W-1:0]  ic_rdata;
    logic          ic_ready, ic_done, ic_err;
    logic [31:0]   dc_address;
    logic          dc_read, dc_write;
    logic [W-1:0]  dc_wdata;
    logic [W-1:0]  dc_rdata;
    logic          dc_ready, dc_done, dc_err;
    logic [31:0]   ram_address;
    logic          ram_read, ram_write;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;
    logic          ram_ready, ram_done;

    logic [7:0]    w_ctl;
    assign w_ctl = {ram_read, ram_write, ic_done, ic_err, dc_done, dc_err, ic_ready, dc_ready};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .BUS_WIDTH_BYTES(BWB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ic_address (ic_address),
        .ic_read    (ic_read),
        .ic_rdata   (ic_rdata),
        .ic_ready   (ic_ready),
        .ic_done    (ic_done),
        .ic_err     (ic_err),
        .dc_address (dc_address),
        .dc_read    (dc_read),
        .dc_write   (dc_write),
        .dc_wdata   (dc_wdata),
        .dc_rdata   (dc_rdata),
        .dc_ready   (dc_ready),
        .dc_done    (dc_done),
        .dc_err     (dc_err),
        .ram_address(ram_address),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .ram_done   (ram_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; ic_address = '0; ic_read = 1'b0;
        dc_address = '0; dc_read = 1'b0; dc_write = 1'b0; dc_wdata = '0;
        ram_rdata = '0; ram_ready = 1'b1; ram_done = 1'b0;
        #1 reset_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL reset_ctl: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        n_checks++;
        if (ram_address !== 32'h0) $display("FAIL reset_ram_address: got %h expected 0", ram_address);
        else n_pass++;
        n_checks++;
        if (ram_wdata !== '0 || ic_rdata !== '0 || dc_rdata !== '0)
            $display("FAIL reset_data: got wdata=%h ic_rdata=%h dc_rdata=%h expected all 0",
                     ram_wdata[63:0], ic_rdata[63:0], dc_rdata[63:0]);
        else n_pass++;
        #3 reset_n = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_ic_read();
        ic_address = 32'h0000_1234; ic_read = 1'b1;
        tick(); // cycle 1
        n_checks++;
        if (w_ctl !== C_RD) $display("FAIL icrd_c1_ctl: got %b expected %b", w_ctl, C_RD);
        else n_pass++;
        n_checks++;
        if (ram_address !== 32'h0000_1200) $display("FAIL icrd_addr: got %h expected 00001200", ram_address);
        else n_pass++;
        tick(); // cycle 2
        n_checks++;
        if (w_ctl !== C_RD) $display("FAIL icrd_c2_hold: got %b expected %b", w_ctl, C_RD);
        else n_pass++;
        tick(); // cycle 3: RAM completes
        ram_rdata = P1; ram_done = 1'b1;
        tick(); // cycle 4
        ram_done = 1'b0; ram_rdata = PJ;
        n_checks++;
        if (w_ctl !== C_ICDN) $display("FAIL icrd_c4_done: got %b expected %b", w_ctl, C_ICDN);
        else n_pass++;
        n_checks++;
        if (ic_rdata !== P1) $display("FAIL icrd_rdata: got %h expected %h", ic_rdata[63:0], P1[63:0]);
        else n_pass++;
        ic_read = 1'b0;
        tick(); // cycle 5
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL icrd_c5_idle: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        n_checks++;
        if (ic_rdata !== P1) $display("FAIL icrd_rdata_stable: got %h expected %h", ic_rdata[63:0], P1[63:0]);
        else n_pass++;
        $display("txn ic read 00001234 -> line 00001200");
    endtask

    task automatic test_tie_dc_first();
        ic_address = 32'h0000_2040; ic_read = 1'b1;
        dc_address = 32'h0000_ABCD; dc_write = 1'b1; dc_wdata = P2;
        tick(); // cycle 1: DC wins (last grant IC)
        n_checks++;
        if (w_ctl !== C_WR) $display("FAIL tie1_grant_dc: got %b expected %b", w_ctl, C_WR);
        else n_pass++;
        n_checks++;
        if (ram_address !== 32'h0000_AB00 || ram_wdata !== P2)
            $display("FAIL tie1_dc_bus: got addr=%h wdata=%h expected addr=0000ab00 wdata=%h",
                     ram_address, ram_wdata[63:0], P2[63:0]);
        else n_pass++;
        ram_done = 1'b1;
        tick(); // cycle 2
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_DCDN) $display("FAIL tie1_dc_done: got %b expected %b", w_ctl, C_DCDN);
        else n_pass++;
        n_checks++;
        if (dc_rdata !== '0) $display("FAIL tie1_dc_rdata_untouched: got %h expected 0", dc_rdata[63:0]);
        else n_pass++;
        dc_write = 1'b0;
        tick(); // cycle 3: idle, IC still requesting
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL tie1_gap_idle: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        tick(); // cycle 4: IC served
        n_checks++;
        if (w_ctl !== C_RD || ram_address !== 32'h0000_2000)
            $display("FAIL tie1_ic_next: got ctl=%b addr=%h expected ctl=%b addr=00002000", w_ctl, ram_address, C_RD);
        else n_pass++;
        ram_rdata = P3; ram_done = 1'b1;
        tick(); // cycle 5
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_ICDN || ic_rdata !== P3)
            $display("FAIL tie1_ic_done: got ctl=%b rdata=%h expected ctl=%b rdata=%h", w_ctl, ic_rdata[63:0], C_ICDN, P3[63:0]);
        else n_pass++;
        ic_read = 1'b0;
        tick();
        $display("txn tie: dc write 0000ab00 then ic read 00002000");
    endtask

    task automatic test_rw_both();
        dc_address = 32'h0000_FFFF; dc_read = 1'b1; dc_write = 1'b1; dc_wdata = P4;
        tick();
        n_checks++;
        if (w_ctl !== C_WR || ram_address !== 32'h0000_FF00 || ram_wdata !== P4)
            $display("FAIL rw_both_write: got ctl=%b addr=%h wdata=%h expected ctl=%b addr=0000ff00 wdata=%h",
                     w_ctl, ram_address, ram_wdata[63:0], C_WR, P4[63:0]);
        else n_pass++;
        ram_rdata = P5; ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_DCDN || dc_rdata !== '0)
            $display("FAIL rw_both_done: got ctl=%b rdata=%h expected ctl=%b rdata=0", w_ctl, dc_rdata[63:0], C_DCDN);
        else n_pass++;
        dc_read = 1'b0; dc_write = 1'b0;
        tick();
        $display("txn dc read+write 0000ffff treated as write");
    endtask

    task automatic test_tie_ic_first();
        ic_address = 32'h0000_0300; ic_read = 1'b1;
        dc_address = 32'h0000_0480; dc_read = 1'b1;
        tick(); // last grant DC, so IC wins
        n_checks++;
        if (w_ctl !== C_RD || ram_address !== 32'h0000_0300)
            $display("FAIL tie2_grant_ic: got ctl=%b addr=%h expected ctl=%b addr=00000300", w_ctl, ram_address, C_RD);
        else n_pass++;
        ram_rdata = P6; ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_ICDN || ic_rdata !== P6)
            $display("FAIL tie2_ic_done: got ctl=%b rdata=%h expected ctl=%b rdata=%h", w_ctl, ic_rdata[63:0], C_ICDN, P6[63:0]);
        else n_pass++;
        ic_read = 1'b0;
        tick();
        tick(); // DC served
        n_checks++;
        if (w_ctl !== C_RD || ram_address !== 32'h0000_0400)
            $display("FAIL tie2_dc_next: got ctl=%b addr=%h expected ctl=%b addr=00000400", w_ctl, ram_address, C_RD);
        else n_pass++;
        ram_rdata = P7; ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_DCDN || dc_rdata !== P7 || ic_rdata !== P6)
            $display("FAIL tie2_dc_done: got ctl=%b dc=%h ic=%h expected ctl=%b dc=%h ic=%h",
                     w_ctl, dc_rdata[63:0], ic_rdata[63:0], C_DCDN, P7[63:0], P6[63:0]);
        else n_pass++;
        dc_read = 1'b0;
        tick();
        $display("txn tie: ic read 00000300 then dc read 00000400");
    endtask

    task automatic test_ram_not_ready();
        ram_ready = 1'b0; ic_address = 32'h0000_0500; ic_read = 1'b1;
        tick(); tick();
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL ram_busy_wait: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        ram_ready = 1'b1;
        tick();
        n_checks++;
        if (w_ctl !== C_RD) $display("FAIL ram_ready_start: got %b expected %b", w_ctl, C_RD);
        else n_pass++;
        ram_rdata = P1; ram_done = 1'b1;
        tick();
        ram_done = 1'b0; ic_read = 1'b0;
        tick();
        $display("txn ic read 00000500 after ram_ready");
    endtask

    task automatic test_ram_done_idle();
        ram_rdata = PJ; ram_done = 1'b1;
        tick();
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL idle_ram_done_c1: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        tick();
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_IDLE || ic_rdata !== P1 || dc_rdata !== P7)
            $display("FAIL idle_ram_done_c2: got ctl=%b ic=%h dc=%h expected ctl=%b ic=%h dc=%h",
                     w_ctl, ic_rdata[63:0], dc_rdata[63:0], C_IDLE, P1[63:0], P7[63:0]);
        else n_pass++;
        $display("txn stray ram_done while idle");
    endtask

    task automatic test_reset_mid_busy();
        ic_address = 32'h0000_0600; ic_read = 1'b1;
        tick();
        n_checks++;
        if (w_ctl !== C_RD) $display("FAIL abort_busy: got %b expected %b", w_ctl, C_RD);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (w_ctl !== C_IDLE || ram_address !== 32'h0 || ic_rdata !== '0 || dc_rdata !== '0)
            $display("FAIL abort_async_clear: got ctl=%b addr=%h ic=%h dc=%h expected ctl=%b all 0",
                     w_ctl, ram_address, ic_rdata[63:0], dc_rdata[63:0], C_IDLE);
        else n_pass++;
        ic_read = 1'b0; ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        tick();
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL abort_no_done: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        ic_address = 32'h0000_07FF; ic_read = 1'b1;
        tick();
        n_checks++;
        if (w_ctl !== C_RD || ram_address !== 32'h0000_0700)
            $display("FAIL post_reset_start: got ctl=%b addr=%h expected ctl=%b addr=00000700", w_ctl, ram_address, C_RD);
        else n_pass++;
        ram_rdata = P2; ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        n_checks++;
        if (w_ctl !== C_ICDN || ic_rdata !== P2)
            $display("FAIL post_reset_done: got ctl=%b rdata=%h expected ctl=%b rdata=%h", w_ctl, ic_rdata[63:0], C_ICDN, P2[63:0]);
        else n_pass++;
        ic_read = 1'b0;
        tick();
        $display("txn reset during busy, then ic read 000007ff");
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        dc_address = 32'h0000_0800; dc_read = 1'b1;
        tick(); // BUSY cycle 1
        repeat (TMO - 1) tick(); // BUSY cycle TMO
        n_checks++;
        if (w_ctl !== C_RD) $display("FAIL tmo_last_busy: got %b expected %b", w_ctl, C_RD);
        else n_pass++;
        tick();
        n_checks++;
        if (w_ctl !== C_DCERR || dc_rdata !== '0)
            $display("FAIL tmo_done_err: got ctl=%b rdata=%h expected ctl=%b rdata=0", w_ctl, dc_rdata[63:0], C_DCERR);
        else n_pass++;
        dc_read = 1'b0;
        tick();
        n_checks++;
        if (w_ctl !== C_IDLE) $display("FAIL tmo_idle: got %b expected %b", w_ctl, C_IDLE);
        else n_pass++;
        $display("txn dc read 00000800 timed out");
    endtask
`endif

    initial begin
        test_reset();
        test_ic_read();
        test_tie_dc_first();
        test_rw_both();
        test_tie_ic_first();
        test_ram_not_ready();
        test_ram_done_idle();
        test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
